// File: rtl/cntr_updn_mod_nb.sv
`default_nettype none
// ============================================================================
// Module   : cntr_updn_mod_nb
// Brief    : n-bit up/down counter, programmable terminal value, load,
//            wrap or saturate mode, registered one-cycle wrap strobe.
// Revision : 1.0 - initial release
// ============================================================================
module cntr_updn_mod_nb #(
  parameter int n   = 8,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic         up,
  input  logic         ld,
  input  logic [n-1:0] D,
  input  logic [n-1:0] max,
  output logic [n-1:0] count,
  output logic         rco,
  output logic         wrap
);

  localparam logic [n-1:0] c_ONE  = {{(n-1){1'b0}}, 1'b1};
  localparam logic [n-1:0] c_ZERO = '0;

  logic [n-1:0] r_count;
  logic         r_wrap;
  logic         w_at_top;
  logic         w_at_zero;
  logic         w_above;
  logic [n-1:0] w_load_val;

  assign w_at_top   = (r_count >= max);
  assign w_at_zero  = (r_count == c_ZERO);
  assign w_above    = (r_count > max);
  assign w_load_val = (D > max) ? max : D;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_count <= c_ZERO;
      r_wrap  <= 1'b0;
    end else if (ld) begin
      r_count <= w_load_val;
      r_wrap  <= 1'b0;
    end else if (en) begin
      if (up) begin
        if (!w_at_top) begin
          r_count <= r_count + c_ONE;
          r_wrap  <= 1'b0;
        end else if (SAT) begin
          r_wrap  <= 1'b0;
        end else begin
          r_count <= c_ZERO;
          r_wrap  <= 1'b1;
        end
      end else begin
        // A count stranded above a lowered max snaps back to the new limit.
        if (w_above) begin
          r_count <= max;
          r_wrap  <= 1'b0;
        end else if (!w_at_zero) begin
          r_count <= r_count - c_ONE;
          r_wrap  <= 1'b0;
        end else if (SAT) begin
          r_wrap  <= 1'b0;
        end else begin
          r_count <= max;
          r_wrap  <= 1'b1;
        end
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign count = r_count;
  assign wrap  = r_wrap;
  assign rco   = (up & w_at_top) | (~up & w_at_zero);

endmodule
`default_nettype wire

// File: tb/tb_cntr_updn_mod_nb.sv
`default_nettype none
// ============================================================================
// Module   : tb_cntr_updn_mod_nb
// Brief    : Bench for cntr_updn_mod_nb, wrap and saturate builds side by side.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cntr_updn_mod_nb;

  logic       clk = 1'b0;
  logic       clr = 1'b0, en = 1'b0, up = 1'b1, ld = 1'b0;
  logic [7:0] D = '0, max = '0;
  logic [7:0] count0, count1;
  logic       rco0, rco1, wrap0, wrap1;

  int n_checks = 0;
  int n_errors = 0;
  int m0_cnt = 0, m0_wrap = 0, m1_cnt = 0, m1_wrap = 0;

  always #5 clk = ~clk;

  cntr_updn_mod_nb #(.n(8), .SAT(1'b0)) u_wrap (
    .clk(clk), .clr(clr), .en(en), .up(up), .ld(ld), .D(D), .max(max),
    .count(count0), .rco(rco0), .wrap(wrap0)
  );

  cntr_updn_mod_nb #(.n(8), .SAT(1'b1)) u_sat (
    .clk(clk), .clr(clr), .en(en), .up(up), .ld(ld), .D(D), .max(max),
    .count(count1), .rco(rco1), .wrap(wrap1)
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Next-state of an ideal modulo-(max+1) counter, from plain integer arithmetic.
  task automatic model_step(input bit sat, inout int c, inout int w);
    int lim;
    lim = int'(max);
    w = 0;
    if (clr) c = 0;
    else if (ld) c = (int'(D) > lim) ? lim : int'(D);
    else if (en) begin
      if (up) begin
        if (c + 1 <= lim) c = c + 1;
        else if (!sat) begin c = 0; w = 1; end
      end else begin
        if (c > lim) c = lim;
        else if (c - 1 >= 0) c = c - 1;
        else if (!sat) begin c = lim; w = 1; end
      end
    end
  endtask

  function automatic int exp_rco(input int c);
    return up ? int'(c >= int'(max)) : int'(c == 0);
  endfunction

  task automatic check_all(input string tag);
    chk({tag, " count0"}, int'(count0), m0_cnt);
    chk({tag, " wrap0"},  int'(wrap0),  m0_wrap);
    chk({tag, " rco0"},   int'(rco0),   exp_rco(m0_cnt));
    chk({tag, " count1"}, int'(count1), m1_cnt);
    chk({tag, " wrap1"},  int'(wrap1),  m1_wrap);
    chk({tag, " rco1"},   int'(rco1),   exp_rco(m1_cnt));
  endtask

  task automatic step(input string tag);
    model_step(1'b0, m0_cnt, m0_wrap);
    model_step(1'b1, m1_cnt, m1_wrap);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    clr = 0; ld = 0; en = 0;
  endtask

  initial begin
    clr = 1;
    step("init");
    idle();

    // T1: clr beats ld and en; nothing changes before the edge
    max = 8'hFF; D = 8'h5A; ld = 1;
    step("t1 load");
    chk("t1 preload", int'(count0), 8'h5A);
    clr = 1; ld = 1; en = 1; D = 8'h11;
    #2;
    chk("t1 before edge", int'(count0), 8'h5A);
    step("t1 clr");
    chk("t1 zero", int'(count0), 0);
    chk("t1 wrap", int'(wrap0), 0);
    idle();

    // T2: up wrap at max = 9
    max = 8'd9; up = 1; en = 1;
    for (int i = 0; i < 12; i++) step("t2 up");
    chk("t2 end", int'(count0), 2);
    idle();

    // T3: down wrap at max = 4
    max = 8'd4; D = 8'd2; ld = 1;
    step("t3 load");
    ld = 0; up = 0; en = 1;
    for (int i = 0; i < 4; i++) step("t3 down");
    chk("t3 end", int'(count0), 3);
    idle();

    // T4: saturation near the top of the range, then at zero
    max = 8'hFF; D = 8'hFD; ld = 1;
    step("t4 load");
    ld = 0; up = 1; en = 1;
    for (int i = 0; i < 5; i++) step("t4 up");
    chk("t4 sat top", int'(count1), 8'hFF);
    idle();
    D = 8'd1; ld = 1;
    step("t4 load1");
    ld = 0; up = 0; en = 1;
    for (int i = 0; i < 2; i++) step("t4 down");
    chk("t4 sat zero", int'(count1), 0);
    idle();

    // T5: load clamp with en also high, then clamp on lowered max
    max = 8'd20; D = 8'd50; ld = 1; en = 1;
    step("t5 clamp");
    chk("t5 clamp val", int'(count0), 20);
    ld = 0; max = 8'd10; up = 0;
    step("t5 lower");
    chk("t5 lower val", int'(count0), 10);
    idle();

    // T6: max = 0 in both directions
    max = 8'd0; en = 1;
    for (int i = 0; i < 6; i++) begin
      up = i[0];
      step("t6 max0");
    end
    idle();

    // Random traffic, max biased small so limits are hit often
    for (int i = 0; i < 400; i++) begin
      clr = ($urandom_range(0, 49) == 0);
      ld  = ($urandom_range(0, 9) == 0);
      en  = ($urandom_range(0, 3) != 0);
      up  = 1'($urandom);
      D   = 8'($urandom);
      if ($urandom_range(0, 15) == 0)
        max = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
